// File: rtl/apb_ctrl_pkg.sv
// Shared definitions for the APB request arbiter.
//   apb_state_e : APB master state encoding (IDLE, SETUP, ACCESS)
//   NUM_REQ     : number of requesters
//   APB_DATA_W  : APB data bus width
package apb_ctrl_pkg;

  localparam int NUM_REQ    = 2;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   PCLK, PRESET : clock, synchronous active-high reset
//   req          : per-requester request
//   upd          : completion strobe; loads the last-grant pointer
//   upd_idx      : index of the requester that just completed
//   gnt_vld      : at least one request pending
//   gnt_idx      : index of the requester to grant
module rr_arbiter2
  import apb_ctrl_pkg::*;
(
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  input  logic               upd_idx,
  output logic               gnt_vld,
  output logic               gnt_idx
);

  logic last_q;

  // On a tie the requester that was not served last wins; otherwise the
  // only requester present wins.
  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = req[1];
    end
  end

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_idx;
    end
  end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Two-requester APB master: round-robin arbitration of transfer requests onto
// a single APB bus (IDLE -> SETUP -> ACCESS).
// Optional feature: define GPIO_APB_ARBITER_TIMEOUT_EN to terminate an ACCESS
// phase with err=1 after TIMEOUT_CYC cycles without PREADY.
// Ports:
//   PCLK, PRESET          : clock, synchronous active-high reset
//   req/req_addr/req_wdata/req_write : per-requester request and payload
//   done                  : one-cycle completion pulse per requester
//   rdata                 : data of the last completed read
//   err                   : error qualifier, valid with done
//   PSEL..PWDATA          : APB master outputs
//   PRDATA, PREADY        : APB master inputs
module gpio_apb_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*APB_DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]      req_write,
  output logic [NUM_REQ-1:0]      done,
  output logic [APB_DATA_W-1:0]   rdata,
  output logic                    err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [ADDR_W-1:0]       PADDR,
  output logic                    PWRITE,
  output logic [APB_DATA_W-1:0]   PWDATA,
  input  logic [APB_DATA_W-1:0]   PRDATA,
  input  logic                    PREADY
);

  apb_state_e state;
  logic       gnt_q;
  logic       arb_vld;
  logic       arb_idx;
  logic       tmo_hit;
  logic       cmpl;

  // Completion (normal or timed out) also advances the arbiter pointer.
  assign cmpl = (state == ACCESS) && (PREADY || tmo_hit);

  rr_arbiter2 u_arb (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .req     (req),
    .upd     (cmpl),
    .upd_idx (gnt_q),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

`ifdef GPIO_APB_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] acc_cnt;
  logic             err_q;

  // Fires in the TIMEOUT_CYC-th ACCESS cycle; PREADY in that same cycle wins.
  assign tmo_hit = (acc_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err     = err_q;
`else
  logic unused_cfg;

  // TIMEOUT_CYC has no role in this build.
  assign unused_cfg = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata   <= '0;
      done    <= '0;
      gnt_q   <= 1'b0;
`ifdef GPIO_APB_ARBITER_TIMEOUT_EN
      err_q   <= 1'b0;
      acc_cnt <= '0;
`endif
    end else begin
      done <= '0;
`ifdef GPIO_APB_ARBITER_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (arb_vld) begin
            // Payload is captured once here; later changes are ignored.
            state   <= SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            gnt_q   <= arb_idx;
            PADDR   <= arb_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            PWDATA  <= arb_idx ? req_wdata[2*APB_DATA_W-1:APB_DATA_W]
                               : req_wdata[APB_DATA_W-1:0];
            PWRITE  <= req_write[arb_idx];
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
`ifdef GPIO_APB_ARBITER_TIMEOUT_EN
          acc_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            done[gnt_q] <= 1'b1;
            if (!PWRITE) begin
              rdata <= PRDATA;
            end
`ifdef GPIO_APB_ARBITER_TIMEOUT_EN
          end else if (tmo_hit) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            done[gnt_q] <= 1'b1;
            err_q       <= 1'b1;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
module tb_gpio_apb_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_write;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        err;
  logic        PSEL;
  logic        PENABLE;
  logic [3:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  int total = 0;
  int bad   = 0;

  gpio_apb_arbiter #(.ADDR_W(4), .TIMEOUT_CYC(15)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_write (req_write),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    PRESET = 1'b1; req = 2'b00; req_addr = '0; req_wdata = '0; req_write = 2'b00;
    PRDATA = '0; PREADY = 1'b0;
    tick(); tick();
    PRESET = 1'b0;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pwrite", PWRITE, 0);

    // req0 write 0xFF to addr 0, PREADY in first ACCESS cycle
    req = 2'b01; req_addr = 8'h00; req_wdata = 64'h0000_0000_0000_00FF;
    req_write = 2'b01; PREADY = 1'b1;
    tick();
    chk("wr_setup_psel", PSEL, 1);
    chk("wr_setup_penable", PENABLE, 0);
    chk("wr_setup_pwdata", PWDATA, 32'hFF);
    chk("wr_setup_pwrite", PWRITE, 1);
    chk("wr_setup_paddr", PADDR, 0);
    tick();
    chk("wr_access_psel", PSEL, 1);
    chk("wr_access_penable", PENABLE, 1);
    chk("wr_access_done", done, 0);
    tick();
    chk("wr_done", done, 2'b01);
    chk("wr_done_err", err, 0);
    chk("wr_done_psel", PSEL, 0);
    chk("wr_done_penable", PENABLE, 0);
    req = 2'b00;
    tick();
    chk("wr_idle_done", done, 0);
    chk("wr_idle_psel", PSEL, 0);

    // req1 read at 0x4 returning 0xA5
    req = 2'b10; req_addr = 8'h40; req_write = 2'b00; PRDATA = 32'h0000_00A5;
    tick();
    chk("rd_setup_paddr", PADDR, 4);
    chk("rd_setup_pwrite", PWRITE, 0);
    tick();
    chk("rd_access_penable", PENABLE, 1);
    tick();
    chk("rd_done", done, 2'b10);
    chk("rd_rdata", rdata, 32'hA5);
    req = 2'b00;
    tick();
    // req1 write afterwards; rdata must keep 0xA5
    req = 2'b10; req_addr = 8'h50; req_wdata = 64'h1234_5678_0000_0000;
    req_write = 2'b10; PRDATA = 32'hDEAD_BEEF;
    tick();
    chk("wr2_setup_pwdata", PWDATA, 32'h1234_5678);
    tick(); tick();
    chk("wr2_done", done, 2'b10);
    chk("wr2_rdata_hold", rdata, 32'hA5);
    req = 2'b00;
    tick();

    // both requesting continuously: grants 0,1,0,1 with an idle cycle between
    req = 2'b11; req_addr = 8'h31; req_write = 2'b11; PREADY = 1'b1;
    tick();
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("rr%0d_setup_psel", t), PSEL, 1);
      chk($sformatf("rr%0d_setup_paddr", t), PADDR, (t % 2 == 0) ? 32'd1 : 32'd3);
      tick();
      chk($sformatf("rr%0d_access_penable", t), PENABLE, 1);
      tick();
      chk($sformatf("rr%0d_idle_psel", t), PSEL, 0);
      chk($sformatf("rr%0d_done", t), done, (t % 2 == 0) ? 32'd1 : 32'd2);
      if (t == 3) req = 2'b00;
      tick();
    end
    chk("rr_end_psel", PSEL, 0);

    // req0 read with PREADY late: 5 ACCESS cycles, payload changed mid-way
    req = 2'b01; req_addr = 8'h07; req_wdata = 64'h0000_0000_CAFE_0000;
    req_write = 2'b00; PREADY = 1'b0; PRDATA = 32'h77;
    tick();
    chk("slow_setup_paddr", PADDR, 7);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("slow%0d_psel", i), PSEL, 1);
      chk($sformatf("slow%0d_penable", i), PENABLE, 1);
      chk($sformatf("slow%0d_paddr", i), PADDR, 7);
      chk($sformatf("slow%0d_pwrite", i), PWRITE, 0);
      chk($sformatf("slow%0d_pwdata", i), PWDATA, 32'hCAFE_0000);
      chk($sformatf("slow%0d_done", i), done, 0);
      if (i == 0) begin
        req_addr = 8'h09; req_wdata = 64'h0000_0000_0BAD_0BAD; req_write = 2'b01;
      end
      if (i == 4) PREADY = 1'b1;
      tick();
    end
    chk("slow_done", done, 2'b01);
    chk("slow_rdata", rdata, 32'h77);
    req = 2'b00; PREADY = 1'b0;
    tick();
    chk("slow_single_done", done, 0);

    // reset during ACCESS; pointer (last=0) must return to 1
    req = 2'b01; req_addr = 8'h03; req_write = 2'b01;
    tick(); tick();
    chk("abort_access_penable", PENABLE, 1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("abort_psel", PSEL, 0);
    chk("abort_penable", PENABLE, 0);
    chk("abort_done", done, 0);
    chk("abort_rdata", rdata, 0);
    req = 2'b11; req_addr = 8'hBA; req_write = 2'b00; PRDATA = 32'h3C; PREADY = 1'b1;
    tick();
    chk("post_rst_tie_paddr", PADDR, 32'hA);
    tick();
    chk("post_rst_abort_nodone", done, 0);
    tick();
    chk("post_rst_done", done, 2'b01);
    chk("post_rst_rdata", rdata, 32'h3C);
    req = 2'b00;
    tick();

    // req1 read with PREADY held low
    req = 2'b10; req_addr = 8'h20; req_write = 2'b00; PREADY = 1'b0; PRDATA = 32'h55;
    tick();
    chk("hang_setup_paddr", PADDR, 2);
    tick();
`ifdef GPIO_APB_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tmo%0d_penable", i), PENABLE, 1);
      chk($sformatf("tmo%0d_done", i), done, 0);
      tick();
    end
    chk("tmo_done", done, 2'b10);
    chk("tmo_err", err, 1);
    chk("tmo_rdata", rdata, 32'h3C);
    chk("tmo_psel", PSEL, 0);
    req = 2'b00;
    tick();
    chk("tmo_after_err", err, 0);
    chk("tmo_after_done", done, 0);
`else
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("wait%0d_penable", i), PENABLE, 1);
      chk($sformatf("wait%0d_done", i), done, 0);
      chk($sformatf("wait%0d_err", i), err, 0);
      tick();
    end
    PREADY = 1'b1;
    tick();
    chk("wait_done", done, 2'b10);
    chk("wait_err", err, 0);
    chk("wait_rdata", rdata, 32'h55);
    req = 2'b00; PREADY = 1'b0;
    tick();
    chk("wait_after_done", done, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
